// File: rtl/timer_countdown_mmss.sv
// rtl/timer_countdown_mmss.sv - M:SS BCD cook-time register with keypad entry and 1 Hz countdown
module timer_countdown_mmss #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic [3:0]  SEC_TENS_RELOAD = 4'd5
) (
    input  logic       CLK_100HZ,
    input  logic       CLR_N,
    input  logic [3:0] D,
    input  logic       LOAD_N,
    input  logic       EN_N,
    input  logic       TICK_1HZ,
    input  logic       CANCEL,
    output logic [3:0] SEC_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] MIN_ONES,
    output logic       ZERO,
    output logic       DONE
);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [SYNC_STAGES-1:0]          load_sync_q, load_sync_d;
    logic [SYNC_STAGES-1:0][3:0]     d_sync_q, d_sync_d;
    logic                            load_prev_q, load_prev_d;
    logic [3:0]                      sec_ones_q, sec_ones_d;
    logic [3:0]                      sec_tens_q, sec_tens_d;
    logic [3:0]                      min_ones_q, min_ones_d;
    logic                            zero_q, zero_d;
    logic                            done_q, done_d;

    logic                            load_event;
    logic [3:0]                      d_synced;
    logic [3:0]                      dec_sec_ones, dec_sec_tens, dec_min_ones;
    logic                            dec_is_zero;

    // Synchronizer chains idle high so that reset release never looks like a key press
    always_comb begin
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], LOAD_N};
        d_sync_d    = {d_sync_q[SYNC_STAGES-2:0], D};
        load_prev_d = load_sync_q[SYNC_STAGES-1];
        load_event  = ~load_sync_q[SYNC_STAGES-1] & load_prev_q;
        d_synced    = d_sync_q[SYNC_STAGES-1];
    end

    // One-second borrow chain; only meaningful when the value is non-zero
    always_comb begin
        dec_sec_ones = sec_ones_q;
        dec_sec_tens = sec_tens_q;
        dec_min_ones = min_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_sec_ones = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_sec_ones = 4'd9;
            dec_sec_tens = sec_tens_q - 4'd1;
        end else if (min_ones_q != 4'd0) begin
            dec_sec_ones = 4'd9;
            dec_sec_tens = SEC_TENS_RELOAD;
            dec_min_ones = min_ones_q - 4'd1;
        end
        dec_is_zero = (dec_sec_ones == 4'd0) && (dec_sec_tens == 4'd0)
                   && (dec_min_ones == 4'd0);
    end

    // State is resolved first; the datapath then acts on both current and next state
    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        done_d     = 1'b0;

        if (CANCEL) begin
            state_d    = ST_ENTRY;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (EN_N && !zero_q) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (!EN_N) begin
                        state_d = ST_ENTRY;
                    end else if (TICK_1HZ && !zero_q) begin
                        sec_ones_d = dec_sec_ones;
                        sec_tens_d = dec_sec_tens;
                        min_ones_d = dec_min_ones;
                        if (dec_is_zero) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (!EN_N) begin
                        state_d = ST_ENTRY;
                    end
                end
                default: state_d = ST_ENTRY;
            endcase

            if ((state_q == ST_ENTRY) && (state_d == ST_ENTRY) && load_event
                && (d_synced <= 4'd9)) begin
                min_ones_d = sec_tens_q;
                sec_tens_d = sec_ones_q;
                sec_ones_d = d_synced;
            end
        end

        zero_d = ~|{min_ones_d, sec_tens_d, sec_ones_d};
    end

    always_ff @(posedge CLK_100HZ or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= ST_ENTRY;
            load_sync_q <= '1;
            d_sync_q    <= '1;
            load_prev_q <= 1'b1;
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            zero_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_sync_q <= load_sync_d;
            d_sync_q    <= d_sync_d;
            load_prev_q <= load_prev_d;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
        end
    end

    assign SEC_ONES = sec_ones_q;
    assign SEC_TENS = sec_tens_q;
    assign MIN_ONES = min_ones_q;
    assign ZERO     = zero_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_timer_countdown_mmss.sv
// tb/tb_timer_countdown_mmss.sv - directed bench for timer_countdown_mmss
module tb_timer_countdown_mmss;

    logic       clk;
    logic       clr_n;
    logic [3:0] d;
    logic       load_n;
    logic       en_n;
    logic       tick;
    logic       cancel;
    logic [3:0] sec_ones, sec_tens, min_ones;
    logic       zero, done;

    int checks = 0;
    int errors = 0;

    timer_countdown_mmss #(
        .SYNC_STAGES    (2),
        .SEC_TENS_RELOAD(4'd5)
    ) dut (
        .CLK_100HZ(clk),
        .CLR_N    (clr_n),
        .D        (d),
        .LOAD_N   (load_n),
        .EN_N     (en_n),
        .TICK_1HZ (tick),
        .CANCEL   (cancel),
        .SEC_ONES (sec_ones),
        .SEC_TENS (sec_tens),
        .MIN_ONES (min_ones),
        .ZERO     (zero),
        .DONE     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [11:0] exp);
        chk(tag, {min_ones, sec_tens, sec_ones}, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] digit);
        d      = digit;
        load_n = 1'b0;
        cycles(20);
        load_n = 1'b1;
        cycles(5);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        clr_n  = 1'b0;
        d      = 4'd0;
        load_n = 1'b1;
        en_n   = 1'b0;
        tick   = 1'b0;
        cancel = 1'b0;
        cycles(3);
        clr_n = 1'b1;
        cycles(1);
        chk_time("reset_digits", 12'h000);
        chk("reset_zero", {11'd0, zero}, 12'd1);
        chk("reset_done", {11'd0, done}, 12'd0);

        // First press: latency of three rising edges
        d      = 4'd1;
        load_n = 1'b0;
        cycles(2);
        chk_time("latency_edge2", 12'h000);
        cycles(1);
        chk_time("latency_edge3", 12'h001);
        cycles(17);
        chk_time("single_shift_hold", 12'h001);
        load_n = 1'b1;
        cycles(5);
        press(4'd3);
        chk_time("entry_13", 12'h013);
        press(4'd0);
        chk_time("entry_130", 12'h130);
        chk("entry_zero", {11'd0, zero}, 12'd0);
        press(4'hC);
        chk_time("entry_d12_ignored", 12'h130);

        // Load 1:00 and count across a minute borrow
        press(4'd1);
        press(4'd0);
        press(4'd0);
        chk_time("load_100", 12'h100);
        en_n = 1'b0;
        en_n = 1'b1;
        cycles(1);
        do_tick();
        chk_time("borrow_059", 12'h059);
        do_tick();
        chk_time("count_058", 12'h058);
        do_tick();
        chk_time("count_057", 12'h057);

        en_n = 1'b0;
        cycles(1);
        press(4'd0);
        press(4'd1);
        press(4'd0);
        chk_time("load_010", 12'h010);
        en_n = 1'b1;
        do_tick();
        chk_time("tick_on_en_rise", 12'h010);
        do_tick();
        chk_time("borrow_009", 12'h009);

        // Expire at 0:00
        en_n = 1'b0;
        cycles(1);
        press(4'd0);
        press(4'd0);
        press(4'd2);
        chk_time("load_002", 12'h002);
        en_n = 1'b1;
        cycles(1);
        do_tick();
        chk_time("expire_001", 12'h001);
        chk("expire_done_early", {11'd0, done}, 12'd0);
        do_tick();
        chk_time("expire_000", 12'h000);
        chk("expire_done", {11'd0, done}, 12'd1);
        chk("expire_zero", {11'd0, zero}, 12'd1);
        cycles(1);
        chk("done_one_cycle", {11'd0, done}, 12'd0);
        do_tick();
        chk_time("expired_tick", 12'h000);
        chk("expired_no_done", {11'd0, done}, 12'd0);

        // Pause holds the value; loads in COUNT are ignored
        en_n = 1'b0;
        cycles(1);
        press(4'd0);
        press(4'd0);
        press(4'd5);
        chk_time("load_005", 12'h005);
        en_n = 1'b1;
        cycles(1);
        do_tick();
        do_tick();
        chk_time("count_003", 12'h003);
        en_n = 1'b0;
        cycles(1);
        do_tick();
        do_tick();
        chk_time("pause_hold", 12'h003);
        en_n = 1'b1;
        cycles(1);
        press(4'd7);
        chk_time("count_load_ignored", 12'h003);

        // CANCEL wins over a coincident final tick
        do_tick();
        do_tick();
        chk_time("count_001", 12'h001);
        cancel = 1'b1;
        tick   = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        tick   = 1'b0;
        chk_time("cancel_000", 12'h000);
        chk("cancel_done", {11'd0, done}, 12'd0);
        chk("cancel_zero", {11'd0, zero}, 12'd1);
        do_tick();
        chk_time("cancel_tick_idle", 12'h000);
        press(4'd4);
        chk_time("cancel_entry_state", 12'h004);
        cycles(1);
        do_tick();
        chk_time("after_cancel_count", 12'h003);

        // Asynchronous reset mid-count
        #2;
        clr_n = 1'b0;
        #1;
        chk_time("async_reset_digits", 12'h000);
        chk("async_reset_zero", {11'd0, zero}, 12'd1);
        en_n = 1'b1;
        @(negedge clk);
        clr_n = 1'b1;
        cycles(5);
        chk_time("post_reset_no_shift", 12'h000);
        chk("post_reset_done", {11'd0, done}, 12'd0);
        do_tick();
        chk_time("zero_stays_entry", 12'h000);
        press(4'd6);
        chk_time("entry_at_zero_en", 12'h006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
